grf_scoreboard: RTL and testbench

Parametrised general register file with an integrated per-register pending-write scoreboard for the pipelined CPU's decode stage. It provides NRD combinational read ports with same-cycle writeback bypass and one writeback port. Per-register in-flight counters track issued-but-not-written destinations, so decode can detect RAW hazards (`rd_busy`) and throttle issue (`iss_ready`). It supersedes the fixed 32x32, two-read-port register file and adds flush, underflow detection and a write trace.

---
 rtl/grf_scoreboard.sv | 104 ++++++++++
 tb/tb_grf_scoreboard.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// General register file with combinational bypassed reads and a per-register
// pending-write scoreboard used by decode for RAW hazard detection and issue throttling.
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int PEND_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    iss_ready,
    input  logic                    wb_valid,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic [31:0]             wb_pc,
    input  logic                    flush,
    output logic                    pend_any,
    output logic                    err_underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [PEND_W-1:0] cnt  [DEPTH];

    logic              wb_live;
    logic              iss_hit;
    logic              iss_acc;
    logic [ADDR_W-1:0] ra   [NRD];
    logic [NRD-1:0]    rhit;
    logic [DEPTH-1:0]  inc_v;
    logic [DEPTH-1:0]  dec_v;

    assign wb_live = wb_valid && (wb_addr != '0);
    assign iss_hit = wb_live && (wb_addr == iss_addr);

    // A full counter still accepts an issue when the same register retires this cycle.
    assign iss_ready = reset && !flush &&
                       ((iss_addr == '0) || (cnt[iss_addr] != CNT_MAX) || iss_hit);
    assign iss_acc   = iss_valid && iss_ready;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            ra[p]   = rd_addr[p*ADDR_W +: ADDR_W];
            rhit[p] = wb_live && (wb_addr == ra[p]);
            if (reset && (ra[p] != '0)) begin
                rd_data[p*DATA_W +: DATA_W] = rhit[p] ? wb_data : regs[ra[p]];
                rd_busy[p] = (cnt[ra[p]] > CNT_ONE) || ((cnt[ra[p]] == CNT_ONE) && !rhit[p]);
            end
        end
    end

    always_comb begin
        inc_v    = '0;
        dec_v    = '0;
        pend_any = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            inc_v[i] = iss_acc && (iss_addr == ADDR_W'(i));
            dec_v[i] = wb_live && (wb_addr == ADDR_W'(i)) && (cnt[i] != '0);
            if (cnt[i] != '0)
                pend_any = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
                if (!flush && (cnt[wb_addr] == '0))
                    err_underflow <= 1'b1;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (flush)
                    cnt[i] <= '0;
                else if (inc_v[i] && !dec_v[i])
                    cnt[i] <= cnt[i] + CNT_ONE;
                else if (dec_v[i] && !inc_v[i])
                    cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && wb_live)
            $display("%d@%h: $%d <= %h", $time, wb_pc, wb_addr, wb_data);
    end
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomised and directed bench for grf_scoreboard against a behavioural
// array/counter model of the register file and scoreboard.
module tb_grf_scoreboard;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int PEND_W = 2;
    localparam int DEPTH  = 32;
    localparam int CMAX   = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_valid;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  iss_ready;
    logic                  wb_valid;
    logic [ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic [31:0]           wb_pc;
    logic                  flush;
    logic                  pend_any;
    logic                  err_underflow;

    always #5 clk = ~clk;

    grf_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .PEND_W(PEND_W)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .flush(flush), .pend_any(pend_any), .err_underflow(err_underflow)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: register contents, in-flight counts, sticky error.
    logic [31:0] mreg [DEPTH];
    int          mcnt [DEPTH];
    bit          merr;

    function automatic bit m_hit(input int a);
        return wb_valid && (int'(wb_addr) == a) && (a != 0);
    endfunction

    function automatic bit exp_ready();
        return reset && !flush &&
               ((iss_addr == 0) || (mcnt[iss_addr] < CMAX) || m_hit(int'(iss_addr)));
    endfunction

    function automatic bit any_pending();
        for (int i = 1; i < DEPTH; i++)
            if (mcnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mreg[i] = '0;
                    mcnt[i] = 0;
                end
                merr = 1'b0;
            end else begin
                bit acc;
                acc = iss_valid && exp_ready();
                if (wb_valid && wb_addr != 0) begin
                    mreg[wb_addr] = wb_data;
                    if (!flush) begin
                        if (mcnt[wb_addr] > 0) mcnt[wb_addr] = mcnt[wb_addr] - 1;
                        else merr = 1'b1;
                    end
                end
                if (flush) begin
                    for (int i = 0; i < DEPTH; i++) mcnt[i] = 0;
                end else if (acc && iss_addr != 0) begin
                    mcnt[iss_addr] = mcnt[iss_addr] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int p = 0; p < NRD; p++) begin
                    int a;
                    logic [31:0] ed;
                    bit eb;
                    a  = int'(rd_addr[p*ADDR_W +: ADDR_W]);
                    ed = (!reset || a == 0) ? 32'h0 : (m_hit(a) ? wb_data : mreg[a]);
                    eb = reset && (a != 0) && ((mcnt[a] > 1) || (mcnt[a] == 1 && !m_hit(a)));
                    chk($sformatf("rd_data%0d", p), 64'(rd_data[p*DATA_W +: DATA_W]), 64'(ed));
                    chk($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(eb));
                end
                chk("iss_ready", 64'(iss_ready), 64'(exp_ready()));
                chk("pend_any", 64'(pend_any), 64'(reset && any_pending()));
                chk("err_underflow", 64'(err_underflow), 64'(merr));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_addr = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
        flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic iss(input int a);
        iss_valid = 1'b1; iss_addr = ADDR_W'(a);
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        wb_valid = 1'b1; wb_addr = ADDR_W'(a); wb_data = d; wb_pc = $urandom;
    endtask

    task automatic reset_pulse();
        cyc(); idle(); reset = 1'b0;
        #1 chk("pulse_err_clear", 64'(err_underflow), 64'h0);
        cyc(); reset = 1'b1;
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 4) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rd_addr = '0;
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        #1 chk("rst_iss_ready", 64'(iss_ready), 64'h0);
        chk("rst_pend_any", 64'(pend_any), 64'h0);
        repeat (2) cyc();
        reset = 1'b1;

        // Idle scan of the whole file after reset.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(); set_rd(0, i); set_rd(1, DEPTH-1-i);
            #1 chk("idle_rd0", 64'(rd_data[31:0]), 64'h0);
            chk("idle_rd1", 64'(rd_data[63:32]), 64'h0);
            chk("idle_busy", 64'(rd_busy), 64'h0);
            chk("idle_ready", 64'(iss_ready), 64'h1);
            chk("idle_pend", 64'(pend_any), 64'h0);
        end

        // Writeback bypass.
        cyc(); idle(); iss(5);
        cyc(); idle(); wb(5, 32'hDEADBEEF); set_rd(0, 5);
        #1 chk("byp_same", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("byp_same_busy", 64'(rd_busy[0]), 64'h0);
        cyc(); idle();
        #1 chk("byp_next", 64'(rd_data[31:0]), 64'hDEADBEEF);
        cyc(); wb(0, 32'h1234); set_rd(0, 0);
        #1 chk("byp_zero", 64'(rd_data[31:0]), 64'h0);
        cyc(); idle();
        #1 chk("byp_zero_noerr", 64'(err_underflow), 64'h0);

        // Scoreboard saturation on $7.
        for (int k = 0; k < 3; k++) begin
            cyc(); idle(); iss(7);
            #1 chk("sat_issue_ready", 64'(iss_ready), 64'h1);
        end
        cyc(); idle(); iss_addr = 7; set_rd(0, 7);
        #1 chk("sat_busy", 64'(rd_busy[0]), 64'h1);
        chk("sat_ready", 64'(iss_ready), 64'h0);
        chk("sat_model_cnt", 64'(mcnt[7]), 64'd3);
        cyc(); iss(7); wb(7, 32'h77);
        #1 chk("sat_swap_ready", 64'(iss_ready), 64'h1);
        cyc(); idle(); iss_addr = 7;
        #1 chk("sat_still_full", 64'(iss_ready), 64'h0);
        chk("sat_model_cnt2", 64'(mcnt[7]), 64'd3);
        for (int k = 0; k < 3; k++) begin
            cyc(); idle(); wb(7, 32'(k));
            #1 chk("sat_drain_busy", 64'(rd_busy[0]), (k < 2) ? 64'h1 : 64'h0);
        end
        cyc(); idle();
        #1 chk("sat_done_busy", 64'(rd_busy[0]), 64'h0);
        chk("sat_done_pend", 64'(pend_any), 64'h0);
        chk("sat_done_err", 64'(err_underflow), 64'h0);

        // Underflow is sticky.
        cyc(); idle(); wb(3, 32'h33); set_rd(0, 3);
        #1 chk("uf_same_err", 64'(err_underflow), 64'h0);
        chk("uf_same_data", 64'(rd_data[31:0]), 64'h33);
        cyc(); idle();
        #1 chk("uf_err", 64'(err_underflow), 64'h1);
        chk("uf_data", 64'(rd_data[31:0]), 64'h33);
        repeat (3) cyc();
        #1 chk("uf_sticky", 64'(err_underflow), 64'h1);
        reset_pulse();

        // Flush clears counts, still writes data, no underflow.
        cyc(); idle(); iss(4);
        cyc(); idle(); iss(9);
        cyc(); idle(); flush = 1'b1; wb(4, 32'h12); iss(9);
        #1 chk("fl_ready", 64'(iss_ready), 64'h0);
        chk("fl_pend_before", 64'(pend_any), 64'h1);
        cyc(); idle(); set_rd(0, 4); set_rd(1, 9);
        #1 chk("fl_pend", 64'(pend_any), 64'h0);
        chk("fl_data", 64'(rd_data[31:0]), 64'h12);
        chk("fl_busy9", 64'(rd_busy[1]), 64'h0);
        chk("fl_err", 64'(err_underflow), 64'h0);
        chk("fl_ready_after", 64'(iss_ready), 64'h1);

        // Asynchronous reset between edges.
        for (int k = 0; k < 3; k++) begin
            cyc(); idle(); iss(6);
        end
        cyc(); idle(); wb(6, 32'h66);
        cyc(); idle(); set_rd(0, 6);
        #1 chk("ar_pend_before", 64'(pend_any), 64'h1);
        chk("ar_data_before", 64'(rd_data[31:0]), 64'h66);
        chk("ar_model_cnt", 64'(mcnt[6]), 64'd2);
        #2 reset = 1'b0;
        #1 chk("ar_pend", 64'(pend_any), 64'h0);
        chk("ar_data", 64'(rd_data[31:0]), 64'h0);
        chk("ar_busy", 64'(rd_busy), 64'h0);
        chk("ar_ready", 64'(iss_ready), 64'h0);
        cyc(); reset = 1'b1;
        #1 chk("ar_reg6", 64'(rd_data[31:0]), 64'h0);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            int r;
            cyc(); idle(); reset = 1'b1;
            set_rd(0, rnd_addr()); set_rd(1, rnd_addr());
            iss_valid = ($urandom_range(0, 9) < 4);
            iss_addr = ADDR_W'(rnd_addr());
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                int s;
                s = int'($urandom_range(1, DEPTH-1));
                for (int j = 0; j < DEPTH-1; j++) begin
                    int a;
                    a = 1 + ((s - 1 + j) % (DEPTH-1));
                    if (!wb_valid && mcnt[a] > 0) wb(a, $urandom);
                end
            end else if (r < 48) begin
                wb(rnd_addr(), $urandom);
            end
            flush = ($urandom_range(0, 49) == 0);
            if (wb_valid && iss_valid && wb_addr == iss_addr && wb_addr != 0 && mcnt[wb_addr] == 0)
                iss_valid = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                #3 reset = 1'b0;
            end
        end
        cyc(); idle(); reset = 1'b1;
        cyc();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
